sound_sequencer: RTL

//  Timed command sequencer and write arbiter in front of the 4-channel square-wave sound block.
//  The CPU queues note events {wait, channel, divider} into an internal FIFO.
//  The sequencer replays them to the sound block's wr_en/data_in bus, with programmable tick delays between events.
//  It also merges direct CPU register writes onto that bus and provides a flush/all-silence sequence.

---
 rtl/sound_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sound_sequencer.sv
// Timed note-event sequencer and write arbiter feeding the 4-channel square-wave sound block.
// Queued {wait, ch, divider} events are replayed with tick delays; direct CPU writes always win the bus.
module sound_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TICK_DIV   = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_wr,
  input  logic [23:0]                  cmd_data,
  output logic                         cmd_ready,
  input  logic                         flush,
  input  logic                         cpu_wr,
  input  logic [15:0]                  cpu_data,
  output logic                         snd_wr_en,
  output logic [15:0]                  snd_data,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_SILENCE = 2'd3;

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [23:0]   r_cur;

  logic [1:0]    r_state;
  logic [1:0]    r_idx;
  logic [7:0]    r_wait_cnt;
  logic [PW-1:0] r_pres;
  logic          r_snd_wr_en;
  logic [15:0]   r_snd_data;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [1:0]    w_state_nxt;
  logic [1:0]    w_idx_nxt;
  logic [7:0]    w_wait_nxt;
  logic [PW-1:0] w_pres_nxt;
  logic          w_wr_nxt;
  logic [15:0]   w_data_nxt;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_state == ST_IDLE) && !w_empty && !flush;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_push  = cmd_wr && !flush && (!w_full || w_pop);

  assign cmd_ready  = !w_full;
  assign busy       = (r_state != ST_IDLE) || !w_empty;
  assign overflow   = r_overflow;
  assign fifo_count = r_count;
  assign snd_wr_en  = r_snd_wr_en;
  assign snd_data   = r_snd_data;

  // Event FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (cmd_wr && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        r_cur <= '0;
    else if (w_pop) r_cur <= r_mem[r_rd_ptr];
  end

  // State and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_wait_cnt  <= '0;
      r_pres      <= '0;
      r_snd_wr_en <= 1'b0;
      r_snd_data  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_pres      <= w_pres_nxt;
      r_snd_wr_en <= w_wr_nxt;
      r_snd_data  <= w_data_nxt;
    end
  end

  // Next state and bus arbitration; a CPU write stalls ISSUE/SILENCE instead of being merged.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_wait_nxt  = r_wait_cnt;
    w_pres_nxt  = r_pres;
    w_wr_nxt    = 1'b0;
    w_data_nxt  = r_snd_data;

    if (cpu_wr) begin
      w_wr_nxt   = 1'b1;
      w_data_nxt = cpu_data;
    end

    if (flush) begin
      w_state_nxt = ST_SILENCE;
      w_idx_nxt   = '0;
      w_wait_nxt  = '0;
      w_pres_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) w_state_nxt = ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!cpu_wr) begin
            w_wr_nxt   = 1'b1;
            w_data_nxt = r_cur[15:0];
            w_pres_nxt = '0;
            if (r_cur[23:16] == 8'd0) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_wait_nxt  = r_cur[23:16];
              w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_pres == PW'(TICK_DIV - 1)) begin
            w_pres_nxt = '0;
            w_wait_nxt = r_wait_cnt - 8'd1;
            if (r_wait_cnt == 8'd1) w_state_nxt = ST_IDLE;
          end else begin
            w_pres_nxt = r_pres + PW'(1);
          end
        end
        ST_SILENCE: begin
          if (!cpu_wr) begin
            w_wr_nxt   = 1'b1;
            w_data_nxt = {r_idx, 14'd0};
            w_idx_nxt  = r_idx + 2'd1;
            if (r_idx == 2'd3) w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

endmodule
